pipe_chain: RTL and testbench
=============================

# pipe_chain

Parametrised elastic pipeline-register chain that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the processor with one generic block. Holds STAGES registers of WIDTH bits, each with a valid bit. Adds what the fixed latches lack: output backpressure, a load-use hold that inserts a bubble, and per-stage flush for branch redirect. Sits between fetch (stage 0 input) and write-back (last stage output); the datapath taps every stage through flat buses for decode, forwarding and hazard logic.

## Interface
- WIDTH, 32, payload bits per stage
- STAGES, 4, number of register stages (≥2)
- HOLD_STAGE, 1, last stage frozen by `hold` (0..STAGES-2); stage HOLD_STAGE+1 receives the bubble

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat offered to stage 0
- in_ready  out  1  stage 0 accepts this cycle
- in_data  in  WIDTH  payload
- hold  in  1  load-use stall request
- flush_mask  in  STAGES  bit i: stage i register becomes invalid at next edge
- out_valid  out  1  = valid of stage STAGES-1
- out_ready  in  1  consumer accepts last stage
- out_data  out  WIDTH  = data of stage STAGES-1
- stage_valid  out  STAGES  valid bit of every stage
- stage_data  out  STAGES*WIDTH  stage i at bits [i*WIDTH +: WIDTH]

## Operation
- Per stage: v[i], d[i]. leave[STAGES-1] = out_ready; leave[i] = acc[i+1] for i<STAGES-1. acc[i] = !v[i] || leave[i].
- hold=1: stages 0..HOLD_STAGE frozen (leave=0, acc=0); stage HOLD_STAGE+1 loads a bubble (v=0, d unchanged) if it can accept; stages beyond advance normally.
- in_ready = acc[0] (0 while hold). Beat accepted when in_valid && in_ready.
- Stage i+1 loads d[i] with v=1 when v[i] && leave[i]; stage i then loads its predecessor's beat or v=0.
- Data registers only written when a valid beat enters; bubbles/flushes leave d unchanged.
- flush_mask[i]=1: v[i] ← 0 at next edge regardless of what would enter; data of an item moving from i to i+1 still moves unless flush_mask[i+1]. Accepted input with flush_mask[0]=1 is dropped (handshake still completes).
- Priority: rst > flush > hold > normal advance.
- No reordering, no duplication; each accepted beat exits at most once.

## Timing
- Reset: all v=0, all d=0; out_valid=0, in_ready=1, stage_valid=0, stage_data=0, counters 0.
- Latency: STAGES cycles from accepted input to out_valid when unstalled; throughput 1 beat/cycle.
- in_ready is combinational from out_ready, hold, and valids (full ready chain, no skid buffer).
- out_ready=0 with all stages full: in_ready=0, contents static.
- Simultaneous hold and out_ready=0: both apply; bubble only inserted if stage HOLD_STAGE+1 empties.
- rst asserted mid-stream: all in-flight beats discarded immediately.

## Configuration
- PIPE_CHAIN_STATS_EN defined: adds outputs retire_count, bubble_count, flush_count (32 bits each, wrap modulo 2^32, reset 0). retire increments on out_valid&&out_ready; bubble increments each cycle hold inserts a bubble into stage HOLD_STAGE+1; flush_count adds popcount of flush_mask & v (valid beats killed, incoming flushed beat at stage 0 counted too).
- Undefined: counters and ports absent; behaviour otherwise identical.

## Test plan
- Default params, out_ready=1, inject 0x11,0x22,0x33 back-to-back → out_data 0x11,0x22,0x33 on cycles 4,5,6 after first accept, out_valid contiguous.
- Fill 4 beats, out_ready=0 for 5 cycles → in_ready=0, stage_valid=4'b1111, data unchanged; release → 4 beats drain in order.
- hold=1 one cycle with stages 0..1 holding 0xA,0xB → stage 2 valid=0 next cycle, 0xA/0xB remain; output shows bubble gap of exactly one cycle.
- flush_mask=4'b0011 while stages hold 0x1..0x4 → 0x1,0x2 never reach output; 0x3,0x4 exit; flush_count=2 with stats enabled.
- Assert rst while full → next cycle stage_valid=0, out_valid=0, in_ready=1, counters 0.
- STAGES=2, WIDTH=8, HOLD_STAGE=0: hold with stage 0 = 0x5A → stage 1 bubble, 0x5A exits one cycle late.

Source files
------------

// File: rtl/pipe_chain.sv
// pipe_chain: elastic chain of STAGES pipeline registers with per-stage valid bits.
//
// Ports
//   clk, rst                     clock; asynchronous active-high reset
//   in_valid / in_ready / in_data  upstream handshake into stage 0
//   hold                         load-use stall: freezes stages 0..HOLD_STAGE and
//                                injects a bubble into stage HOLD_STAGE+1
//   flush_mask                   bit i invalidates stage i at the next edge
//   out_valid / out_ready / out_data  downstream handshake from the last stage
//   stage_valid, stage_data      every stage tapped flat (stage i at [i*WIDTH +: WIDTH])
//
// Optional build macro PIPE_CHAIN_STATS_EN adds 32-bit counters retire_count,
// bubble_count and flush_count.
module pipe_chain #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STAGES     = 4,
  parameter int unsigned HOLD_STAGE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      hold,
  input  logic [STAGES-1:0]         flush_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_data
`ifdef PIPE_CHAIN_STATS_EN
  ,
  output logic [31:0]               retire_count,
  output logic [31:0]               bubble_count,
  output logic [31:0]               flush_count
`endif
);

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] v_pre;   // next valid before flush is applied
  logic [STAGES-1:0] leave;   // beat in stage i moves on this cycle
  logic [STAGES-1:0] acc;     // stage i can take a new beat (or bubble)
  logic [STAGES-1:0] load;    // data register i is written
  logic [WIDTH-1:0]  d_q   [STAGES];
  logic [WIDTH-1:0]  d_src [STAGES];

  // Ready chain evaluated from the output back to stage 0. Under hold the
  // frozen stages neither leave nor accept, so stage HOLD_STAGE+1 naturally
  // receives nothing (a bubble) if it can accept.
  always_comb begin
    logic acc_up;
    logic l;
    logic a;
    leave  = '0;
    acc    = '0;
    acc_up = 1'b0;
    l      = 1'b0;
    a      = 1'b0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      l = (i == int'(STAGES) - 1) ? out_ready : acc_up;
      if (hold && (i <= int'(HOLD_STAGE))) begin
        l = 1'b0;
        a = 1'b0;
      end else begin
        a = !v_q[i] || l;
      end
      leave[i] = l;
      acc[i]   = a;
      acc_up   = a;
    end
  end

  always_comb begin
    v_pre    = v_q;
    load     = '0;
    d_src[0] = in_data;
    if (acc[0]) begin
      v_pre[0] = in_valid;
      load[0]  = in_valid && !flush_mask[0];
    end
    for (int i = 1; i < int'(STAGES); i++) begin
      d_src[i] = d_q[i-1];
      if (acc[i]) begin
        v_pre[i] = v_q[i-1] && leave[i-1];
        load[i]  = v_q[i-1] && leave[i-1] && !flush_mask[i];
      end
    end
    v_d = v_pre & ~flush_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) d_q[i] <= '0;
    end else begin
      v_q <= v_d;
      for (int i = 0; i < int'(STAGES); i++) begin
        if (load[i]) d_q[i] <= d_src[i];
      end
    end
  end

  assign in_ready    = acc[0];
  assign out_valid   = v_q[STAGES-1];
  assign out_data    = d_q[STAGES-1];
  assign stage_valid = v_q;

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_tap
    assign stage_data[g*WIDTH +: WIDTH] = d_q[g];
  end

`ifdef PIPE_CHAIN_STATS_EN
  logic [31:0] retire_q, bubble_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (out_valid && out_ready) retire_q <= retire_q + 32'd1;
      if (hold && acc[HOLD_STAGE+1]) bubble_q <= bubble_q + 32'd1;
      // Counts beats that would have occupied a stage, incl. a flushed input.
      flush_q <= flush_q + 32'($countones(flush_mask & v_pre));
    end
  end

  assign retire_count = retire_q;
  assign bubble_count = bubble_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain: one default instance (4x32, hold stage 1)
// and one small instance (2x8, hold stage 0). Expected beats are queued when
// driven; per-instance monitors pop and compare on each output handshake.
module tb_pipe_chain;

  typedef struct {
    logic [31:0] data;
    int          due;   // expected cycle of appearance, -1 = don't care
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A
  logic         a_in_valid, a_in_ready, a_hold, a_out_valid, a_out_ready;
  logic [31:0]  a_in_data, a_out_data;
  logic [3:0]   a_flush, a_stage_valid;
  logic [127:0] a_stage_data;
  // Instance B
  logic         b_in_valid, b_in_ready, b_hold, b_out_valid, b_out_ready;
  logic [7:0]   b_in_data, b_out_data;
  logic [1:0]   b_flush, b_stage_valid;
  logic [15:0]  b_stage_data;
`ifdef PIPE_CHAIN_STATS_EN
  logic [31:0]  a_retire, a_bubble, a_flushc, b_retire, b_bubble, b_flushc;
`endif

  pipe_chain #(.WIDTH(32), .STAGES(4), .HOLD_STAGE(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .hold(a_hold), .flush_mask(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stage_valid(a_stage_valid), .stage_data(a_stage_data)
`ifdef PIPE_CHAIN_STATS_EN
    , .retire_count(a_retire), .bubble_count(a_bubble), .flush_count(a_flushc)
`endif
  );

  pipe_chain #(.WIDTH(8), .STAGES(2), .HOLD_STAGE(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .hold(b_hold), .flush_mask(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stage_valid(b_stage_valid), .stage_data(b_stage_data)
`ifdef PIPE_CHAIN_STATS_EN
    , .retire_count(b_retire), .bubble_count(b_bubble), .flush_count(b_flushc)
`endif
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_beat: got %0h expected none", a_out_data);
      end else begin
        e = qa.pop_front();
        chk("a_out_data", 128'(a_out_data), 128'(e.data));
        if (e.due >= 0) chk("a_out_cycle", 128'(cyc), 128'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_beat: got %0h expected none", b_out_data);
      end else begin
        e = qb.pop_front();
        chk("b_out_data", 128'(b_out_data), 128'(e.data));
        if (e.due >= 0) chk("b_out_cycle", 128'(cyc), 128'(e.due));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v3 [3];
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_hold = 0; a_flush = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_hold = 0; b_flush = '0; b_out_ready = 1;
    step(); step();

    // Reset state
    chk("rst_in_ready", 128'(a_in_ready), 128'(1'b1));
    chk("rst_stage_valid", 128'(a_stage_valid), 128'(4'h0));
    chk("rst_stage_data", a_stage_data, 128'h0);
    chk("rst_out_valid", 128'(a_out_valid), 128'(1'b0));
    rst = 1'b0;
    step();

    // Back-to-back beats: 4-cycle latency, contiguous output
    v3[0] = 32'h11; v3[1] = 32'h22; v3[2] = 32'h33;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1; a_in_data = v3[k];
      qa.push_back('{v3[k], cyc + 4});
      step();
    end
    a_in_valid = 0;
    repeat (8) step();

    // Fill and backpressure
    a_out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1; a_in_data = 32'hA0 + 32'(k);
      qa.push_back('{32'hA0 + 32'(k), -1});
      step();
    end
    a_in_data = 32'hFF;   // offered but must not be taken
    repeat (5) begin
      chk("full_in_ready", 128'(a_in_ready), 128'(1'b0));
      step();
    end
    chk("full_stage_valid", 128'(a_stage_valid), 128'(4'hF));
    chk("full_stage_data", a_stage_data, {32'hA0, 32'hA1, 32'hA2, 32'hA3});
    a_in_valid = 0; a_out_ready = 1;
    repeat (6) step();

    // Hold for one cycle with stage0=0xA, stage1=0xB, stage2=0xC
    a_in_valid = 1; a_in_data = 32'hC; qa.push_back('{32'hC, cyc + 4}); step();
    a_in_data = 32'hB; qa.push_back('{32'hB, cyc + 5}); step();
    a_in_data = 32'hA; qa.push_back('{32'hA, cyc + 5}); step();
    a_in_valid = 0; a_hold = 1;
    #1;
    chk("hold_in_ready", 128'(a_in_ready), 128'(1'b0));
    step();
    a_hold = 0;
    chk("hold_stage_valid", 128'(a_stage_valid), 128'(4'b1011));
    chk("hold_frozen_data", 128'(a_stage_data[63:0]), 128'({32'hB, 32'hA}));
    repeat (6) step();

    // Flush stages 0,1 of a full, stalled chain (stage0=0x1 .. stage3=0x4)
    a_out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1; a_in_data = 32'h4 - 32'(k);
      if (k < 2) qa.push_back('{32'h4 - 32'(k), -1});
      step();
    end
    a_in_valid = 0; a_flush = 4'b0011;
    step();
    a_flush = 4'b0000;
    chk("flush_stage_valid", 128'(a_stage_valid), 128'(4'b1100));
`ifdef PIPE_CHAIN_STATS_EN
    chk("flush_count", 128'(a_flushc), 128'(32'd2));
`endif
    a_out_ready = 1;
    repeat (6) step();

    // Accepted input flushed at stage 0 still handshakes
    a_in_valid = 1; a_in_data = 32'h77; a_flush = 4'b0001;
    #1;
    chk("flush_in_ready", 128'(a_in_ready), 128'(1'b1));
    step();
    a_in_valid = 0; a_flush = 4'b0000;
    chk("flush_in_dropped", 128'(a_stage_valid), 128'(4'b0000));
    repeat (6) step();

    // Reset mid-stream with the chain full
    a_out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1; a_in_data = 32'hE0 + 32'(k);
      step();
    end
    a_in_valid = 0;
    rst = 1;
    #1;
    chk("midrst_stage_valid", 128'(a_stage_valid), 128'(4'h0));
    chk("midrst_out_valid", 128'(a_out_valid), 128'(1'b0));
    chk("midrst_in_ready", 128'(a_in_ready), 128'(1'b1));
    step();
    chk("midrst_stage_data", a_stage_data, 128'h0);
`ifdef PIPE_CHAIN_STATS_EN
    chk("midrst_retire", 128'(a_retire), 128'(32'd0));
`endif
    rst = 0; a_out_ready = 1;
    repeat (6) step();

    // Small chain: hold at stage 0 delays 0x5A by one cycle
    b_in_valid = 1; b_in_data = 8'h5A; qb.push_back('{32'h5A, cyc + 3});
    step();
    b_in_valid = 0; b_hold = 1;
    #1;
    chk("b_hold_in_ready", 128'(b_in_ready), 128'(1'b0));
    step();
    b_hold = 0;
    chk("b_hold_stage_valid", 128'(b_stage_valid), 128'(2'b01));
    chk("b_hold_stage0", 128'(b_stage_data[7:0]), 128'(8'h5A));
    repeat (4) step();

    chk("a_queue_drained", 128'(qa.size()), 128'(0));
    chk("b_queue_drained", 128'(qb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
